// File: rtl/pipe_redirect_if.sv
// Handshake bundle between the redirect controller and EX/ID/IF/BP-table.
// master = controller side, slave = pipeline/environment side.
interface pipe_redirect_if #(
  parameter int unsigned REG_SZ   = 32,
  parameter int unsigned BP_TAG_W = 10
);
  logic                ex_jp_req;
  logic [REG_SZ-1:0]   ex_jp_pc;
  logic                ex_jp_ack;
  logic                id_jp_req;
  logic [REG_SZ-1:0]   id_jp_pc;
  logic                id_jp_ack;
  logic                if_pc_we;
  logic [REG_SZ-1:0]   if_pc;
  logic                if_pc_ack;
  logic                flush_ifid;
  logic                flush_idex;
  logic                bpu_req;
  logic [BP_TAG_W-1:0] bpu_tag;
  logic                bpu_t;
  logic                bpu_ack;
  logic                bp_we;
  logic [BP_TAG_W-1:0] bp_tag;
  logic                bp_t;
  logic                bp_wack;

  modport master (
    input  ex_jp_req, ex_jp_pc, id_jp_req, id_jp_pc, if_pc_ack,
    input  bpu_req, bpu_tag, bpu_t, bp_wack,
    output ex_jp_ack, id_jp_ack, if_pc_we, if_pc, flush_ifid, flush_idex,
    output bpu_ack, bp_we, bp_tag, bp_t
  );

  modport slave (
    output ex_jp_req, ex_jp_pc, id_jp_req, id_jp_pc, if_pc_ack,
    output bpu_req, bpu_tag, bpu_t, bp_wack,
    input  ex_jp_ack, id_jp_ack, if_pc_we, if_pc, flush_ifid, flush_idex,
    input  bpu_ack, bp_we, bp_tag, bp_t
  );
endinterface

// File: rtl/pipe_redirect_ctrl.sv
// Redirect/flush sequencer (IDLE -> FLUSH -> ISSUE) plus a circular BP-update queue.
// Define REDIRECT_STATS_EN to add saturating stat_redir/stat_preempt counter ports.
module pipe_redirect_ctrl #(
  parameter int unsigned REG_SZ    = 32,
  parameter int unsigned BP_TAG_W  = 10,
  parameter int unsigned BPQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  pipe_redirect_if.master ctrl_io,
  output logic            busy
`ifdef REDIRECT_STATS_EN
  ,
  output logic [31:0]     stat_redir,
  output logic [15:0]     stat_preempt
`endif
);

  localparam int unsigned PtrW = (BPQ_DEPTH > 1) ? $clog2(BPQ_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(BPQ_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StFlush, StIssue} state_e;

  state_e            state_q, state_d;
  logic              src_ex_q, src_ex_d;
  logic [REG_SZ-1:0] pc_q, pc_d;
  logic              ex_ack_q, ex_ack_d;
  logic              id_ack_q, id_ack_d;
  logic              flush_ifid_q, flush_ifid_d;
  logic              flush_idex_q, flush_idex_d;
  logic              pc_we_q, pc_we_d;
  logic              preempt, issue_done;

  // Entry layout: {taken, tag}
  logic [BP_TAG_W:0] mem_q [BPQ_DEPTH];
  logic [BP_TAG_W:0] mem_d [BPQ_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              q_full, q_empty, q_push, q_pop;

`ifdef REDIRECT_STATS_EN
  logic [31:0] stat_redir_q, stat_redir_d;
  logic [15:0] stat_preempt_q, stat_preempt_d;
`endif

  // An older EX redirect overrides an in-flight ID redirect at any point before IF accepts it.
  assign preempt    = (state_q != StIdle) && !src_ex_q && ctrl_io.ex_jp_req;
  assign issue_done = (state_q == StIssue) && pc_we_q && ctrl_io.if_pc_ack && !preempt;

  always_comb begin
    state_d      = state_q;
    src_ex_d     = src_ex_q;
    pc_d         = pc_q;
    ex_ack_d     = 1'b0;
    id_ack_d     = 1'b0;
    flush_ifid_d = 1'b0;
    flush_idex_d = 1'b0;
    pc_we_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_io.ex_jp_req) begin
          pc_d     = ctrl_io.ex_jp_pc;
          src_ex_d = 1'b1;
          ex_ack_d = 1'b1;
          state_d  = StFlush;
        end else if (ctrl_io.id_jp_req) begin
          pc_d     = ctrl_io.id_jp_pc;
          src_ex_d = 1'b0;
          id_ack_d = 1'b1;
          state_d  = StFlush;
        end
      end
      StFlush: begin
        if (preempt) begin
          pc_d     = ctrl_io.ex_jp_pc;
          src_ex_d = 1'b1;
          ex_ack_d = 1'b1;
        end else begin
          flush_ifid_d = 1'b1;
          flush_idex_d = src_ex_q;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        if (preempt) begin
          pc_d     = ctrl_io.ex_jp_pc;
          src_ex_d = 1'b1;
          ex_ack_d = 1'b1;
          state_d  = StFlush;
        end else if (issue_done) begin
          state_d = StIdle;
        end else begin
          pc_we_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Full is judged on the pre-pop count, so a push into a full queue is refused even on a pop.
  assign q_full  = (cnt_q == CntW'(BPQ_DEPTH));
  assign q_empty = (cnt_q == '0);
  assign q_push  = ctrl_io.bpu_req && !q_full;
  assign q_pop   = ctrl_io.bp_wack && !q_empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (q_push) begin
      mem_d[wr_ptr_q] = {ctrl_io.bpu_t, ctrl_io.bpu_tag};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (q_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (q_push && !q_pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (q_pop && !q_push) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

`ifdef REDIRECT_STATS_EN
  always_comb begin
    stat_redir_d   = stat_redir_q;
    stat_preempt_d = stat_preempt_q;
    if (issue_done && (stat_redir_q != '1)) begin
      stat_redir_d = stat_redir_q + 32'd1;
    end
    if (preempt && (stat_preempt_q != '1)) begin
      stat_preempt_d = stat_preempt_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      src_ex_q       <= 1'b0;
      pc_q           <= '0;
      ex_ack_q       <= 1'b0;
      id_ack_q       <= 1'b0;
      flush_ifid_q   <= 1'b0;
      flush_idex_q   <= 1'b0;
      pc_we_q        <= 1'b0;
      mem_q          <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
`ifdef REDIRECT_STATS_EN
      stat_redir_q   <= '0;
      stat_preempt_q <= '0;
`endif
    end else begin
      state_q        <= state_d;
      src_ex_q       <= src_ex_d;
      pc_q           <= pc_d;
      ex_ack_q       <= ex_ack_d;
      id_ack_q       <= id_ack_d;
      flush_ifid_q   <= flush_ifid_d;
      flush_idex_q   <= flush_idex_d;
      pc_we_q        <= pc_we_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
`ifdef REDIRECT_STATS_EN
      stat_redir_q   <= stat_redir_d;
      stat_preempt_q <= stat_preempt_d;
`endif
    end
  end

  assign ctrl_io.ex_jp_ack  = ex_ack_q;
  assign ctrl_io.id_jp_ack  = id_ack_q;
  assign ctrl_io.if_pc_we   = pc_we_q;
  assign ctrl_io.if_pc      = pc_q;
  assign ctrl_io.flush_ifid = flush_ifid_q;
  assign ctrl_io.flush_idex = flush_idex_q;
  assign ctrl_io.bpu_ack    = q_push;
  assign ctrl_io.bp_we      = !q_empty;
  assign ctrl_io.bp_tag     = mem_q[rd_ptr_q][BP_TAG_W-1:0];
  assign ctrl_io.bp_t       = mem_q[rd_ptr_q][BP_TAG_W];
  assign busy               = (state_q != StIdle);

`ifdef REDIRECT_STATS_EN
  assign stat_redir   = stat_redir_q;
  assign stat_preempt = stat_preempt_q;
`endif

endmodule

// File: tb/tb_pipe_redirect_ctrl.sv
// Randomized bench for pipe_redirect_ctrl against a cycle-timeline reference model
// (redirect as "age since accept", BP queue as an SV queue).
module tb_pipe_redirect_ctrl;
  localparam int RegSz = 32;
  localparam int TagW  = 10;
  localparam int Depth = 2;
  localparam int NumCycles = 4000;

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef REDIRECT_STATS_EN
  logic [31:0] stat_redir;
  logic [15:0] stat_preempt;
`endif

  pipe_redirect_if #(.REG_SZ(RegSz), .BP_TAG_W(TagW)) bus_if ();

  pipe_redirect_ctrl #(
    .REG_SZ   (RegSz),
    .BP_TAG_W (TagW),
    .BPQ_DEPTH(Depth)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctrl_io(bus_if),
    .busy   (busy)
`ifdef REDIRECT_STATS_EN
    ,
    .stat_redir  (stat_redir),
    .stat_preempt(stat_preempt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_chk;
  int unsigned n_pass;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
  endtask

  // Reference model: a redirect is "age" cycles old since its accept edge.
  // age 1 = ack pulse, age 2 = flush pulse, age >= 3 = IF write held.
  bit               m_busy;
  bit               m_src_ex;
  logic [RegSz-1:0] m_pc;
  int               m_age;
  int unsigned      m_redirs;
  int unsigned      m_preempts;
  logic [TagW:0]    m_q[$];

  bit ex_ack_seen, id_ack_seen, flush_seen, rst_done;

  task automatic model_reset();
    m_busy = 0; m_src_ex = 0; m_pc = '0; m_age = 0;
    m_redirs = 0; m_preempts = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit was_full;
    was_full = (m_q.size() == Depth);
    if (bus_if.bp_wack && m_q.size() != 0) void'(m_q.pop_front());
    if (bus_if.bpu_req && !was_full) m_q.push_back({bus_if.bpu_t, bus_if.bpu_tag});
    if (!m_busy) begin
      if (bus_if.ex_jp_req) begin
        m_busy = 1; m_src_ex = 1; m_pc = bus_if.ex_jp_pc; m_age = 1;
      end else if (bus_if.id_jp_req) begin
        m_busy = 1; m_src_ex = 0; m_pc = bus_if.id_jp_pc; m_age = 1;
      end
    end else if (!m_src_ex && bus_if.ex_jp_req) begin
      m_src_ex = 1; m_pc = bus_if.ex_jp_pc; m_age = 1;
      if (m_preempts < 32'hFFFF) m_preempts++;
    end else if (m_age >= 3 && bus_if.if_pc_ack) begin
      m_busy = 0; m_age = 0;
      m_redirs++;
    end else if (m_age < 3) begin
      m_age++;
    end
  endtask

  task automatic clear_inputs();
    bus_if.ex_jp_req = 1'b0; bus_if.ex_jp_pc = '0;
    bus_if.id_jp_req = 1'b0; bus_if.id_jp_pc = '0;
    bus_if.if_pc_ack = 1'b0;
    bus_if.bpu_req = 1'b0; bus_if.bpu_tag = '0; bus_if.bpu_t = 1'b0;
    bus_if.bp_wack = 1'b0;
    ex_ack_seen = 0; id_ack_seen = 0; flush_seen = 0;
  endtask

  // Requesters hold their level until acked; ID also withdraws when a flush kills it.
  task automatic drive();
    if (bus_if.ex_jp_req && ex_ack_seen) bus_if.ex_jp_req = 1'b0;
    else if (!bus_if.ex_jp_req && $urandom_range(0, 7) == 0) begin
      bus_if.ex_jp_req = 1'b1;
      bus_if.ex_jp_pc  = $urandom() & 32'hFFFF_FFFC;
    end
    if (bus_if.id_jp_req && (id_ack_seen || flush_seen)) bus_if.id_jp_req = 1'b0;
    else if (!bus_if.id_jp_req && $urandom_range(0, 4) == 0) begin
      bus_if.id_jp_req = 1'b1;
      bus_if.id_jp_pc  = $urandom() & 32'hFFFF_FFFC;
    end
    bus_if.if_pc_ack = ($urandom_range(0, 2) == 0);
    bus_if.bpu_req   = ($urandom_range(0, 1) == 1);
    bus_if.bpu_tag   = TagW'($urandom_range(0, 1023));
    bus_if.bpu_t     = ($urandom_range(0, 1) == 1);
    bus_if.bp_wack   = ($urandom_range(0, 2) == 0);
  endtask

  task automatic check_outputs();
    bit exp_we;
    exp_we = m_busy && m_age >= 3;
    check_val("busy",       64'(busy),              64'(m_busy));
    check_val("ex_jp_ack",  64'(bus_if.ex_jp_ack),  64'(m_busy && m_age == 1 && m_src_ex));
    check_val("id_jp_ack",  64'(bus_if.id_jp_ack),  64'(m_busy && m_age == 1 && !m_src_ex));
    check_val("flush_ifid", 64'(bus_if.flush_ifid), 64'(m_busy && m_age == 2));
    check_val("flush_idex", 64'(bus_if.flush_idex), 64'(m_busy && m_age == 2 && m_src_ex));
    check_val("if_pc_we",   64'(bus_if.if_pc_we),   64'(exp_we));
    if (exp_we) check_val("if_pc", 64'(bus_if.if_pc), 64'(m_pc));
    check_val("bp_we",      64'(bus_if.bp_we),      64'(m_q.size() != 0));
    if (m_q.size() != 0) check_val("bp_head", 64'({bus_if.bp_t, bus_if.bp_tag}), 64'(m_q[0]));
    check_val("bpu_ack", 64'(bus_if.bpu_ack), 64'(bus_if.bpu_req && m_q.size() < Depth));
`ifdef REDIRECT_STATS_EN
    check_val("stat_redir",   64'(stat_redir),   64'(m_redirs));
    check_val("stat_preempt", 64'(stat_preempt), 64'(m_preempts));
`endif
    ex_ack_seen = bus_if.ex_jp_ack;
    id_ack_seen = bus_if.id_jp_ack;
    flush_seen  = bus_if.flush_ifid;
  endtask

  task automatic check_idle_outputs(input string pfx);
    check_val({pfx, "_busy"},     64'(busy),              64'(0));
    check_val({pfx, "_if_pc_we"}, 64'(bus_if.if_pc_we),   64'(0));
    check_val({pfx, "_bp_we"},    64'(bus_if.bp_we),      64'(0));
    check_val({pfx, "_ex_ack"},   64'(bus_if.ex_jp_ack),  64'(0));
    check_val({pfx, "_id_ack"},   64'(bus_if.id_jp_ack),  64'(0));
    check_val({pfx, "_flush"},    64'({bus_if.flush_ifid, bus_if.flush_idex}), 64'(0));
  endtask

  initial begin
    n_chk = 0; n_pass = 0; rst_done = 0;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #12;
    check_idle_outputs("reset");
    check_val("reset_if_pc", 64'(bus_if.if_pc), 64'(0));
    check_val("reset_bpu_ack", 64'(bus_if.bpu_ack), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < NumCycles; cyc++) begin
      @(posedge clk);
      #1;
      model_step();
      drive();
      @(negedge clk);
      check_outputs();
      // Asynchronous reset mid-redirect with an update queued: must clear immediately.
      if (!rst_done && cyc > 300 && m_busy && m_age >= 3 && m_q.size() != 0) begin
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        clear_inputs();
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        rst_done = 1;
      end
    end
    check_val("mid_reset_reached", 64'(rst_done), 64'(1));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
